divider_arbiter: RTL and testbench

Shares one multi-cycle 64-bit divider (valid/vld/busy handshake) among NREQ requesters. Round-robin grant, operand capture, single-cycle issue pulse, completion wait with timeout, and per-requester response with backpressure. Sits between the client ports and the divider instance. Divide-by-zero is resolved locally without occupying the divider.

---
 rtl/divider_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/divider_arbiter.sv | 144 ++++++++++++++
 tb/tb_divider_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_arb_pkg.sv
// ============================================================================
// Module   : divider_arb_pkg
// Brief    : Shared types and constants for the divider arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 64;

  // Quotient reported for a zero divisor.
  localparam logic [DATA_W_DEF-1:0] QUOT_DBZ = {DATA_W_DEF{1'b1}};

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin grant: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] w_k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    w_k = '0;
    for (int i = 0; i < N; i++) begin
      w_k = {1'b0, ptr} + (IW+1)'(i);
      if (w_k >= (IW+1)'(N)) begin
        w_k = w_k - (IW+1)'(N);
      end
      if (!any && req[w_k[IW-1:0]]) begin
        any               = 1'b1;
        gnt[w_k[IW-1:0]]  = 1'b1;
        idx               = w_k[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/divider_arbiter.sv
// ============================================================================
// Module   : divider_arbiter
// Brief    : Round-robin sharing of one multi-cycle divider among NREQ clients.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_arbiter
  import divider_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_dividend,
  input  logic [NREQ*DATA_W-1:0] req_divisor,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]      rsp_quotient,
  output logic                   rsp_dbz,
  output logic                   rsp_err,
  output logic                   div_valid,
  output logic [DATA_W-1:0]      div_dividend,
  output logic [DATA_W-1:0]      div_divisor,
  input  logic [DATA_W-1:0]      div_quotient,
  input  logic                   div_vld,
  input  logic                   div_busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             r_state, w_next_state;
  logic [IDX_W-1:0]   r_owner, r_rr_ptr;
  logic [DATA_W-1:0]  r_dividend, r_divisor, r_quotient;
  logic               r_dbz, r_err, r_armed;
  logic [CNT_W-1:0]   r_cnt;

  logic [NREQ-1:0]    w_gnt;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_any, w_accept, w_done, w_tmo, w_handshake;
  logic [DATA_W-1:0]  w_sel_dividend, w_sel_divisor;

  rr_arbiter #(.N(NREQ), .IW(IDX_W)) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_rr_ptr),
    .gnt (w_gnt),
    .idx (w_gnt_idx),
    .any (w_any)
  );

  assign w_sel_dividend = req_dividend[w_gnt_idx*DATA_W +: DATA_W];
  assign w_sel_divisor  = req_divisor[w_gnt_idx*DATA_W +: DATA_W];
  assign w_accept       = (r_state == ST_IDLE) && w_any;
  // A completion only counts once vld has been seen low in this WAIT.
  assign w_done         = r_armed && div_vld;
  assign w_tmo          = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_handshake    = (r_state == ST_RESP) && rsp_ready[r_owner];

  assign req_ready    = (r_state == ST_IDLE && arst) ? w_gnt : '0;
  assign div_valid    = (r_state == ST_ISSUE) && !div_busy;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign rsp_quotient = r_quotient;
  assign rsp_dbz      = r_dbz;
  assign rsp_err      = r_err;

  always_comb begin
    rsp_valid = '0;
    if (r_state == ST_RESP) begin
      rsp_valid[r_owner] = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next_state = (w_sel_divisor == '0) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (!div_busy) w_next_state = ST_WAIT;
      ST_WAIT:  if (w_done || w_tmo) w_next_state = ST_RESP;
      ST_RESP:  if (w_handshake) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quotient <= '0;
      r_dbz      <= 1'b0;
      r_err      <= 1'b0;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner    <= w_gnt_idx;
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
            if (w_sel_divisor == '0) begin
              r_quotient <= QUOT_DBZ[DATA_W-1:0];
              r_dbz      <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_armed <= 1'b0;
          r_cnt   <= '0;
        end
        ST_WAIT: begin
          if (!div_vld) r_armed <= 1'b1;
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_quotient <= div_quotient;
          end else if (w_tmo) begin
            r_quotient <= '0;
            r_err      <= 1'b1;
          end
        end
        ST_RESP: begin
          if (w_handshake) begin
            r_dbz    <= 1'b0;
            r_err    <= 1'b0;
            r_rr_ptr <= (r_owner == IDX_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_arbiter.sv
// ============================================================================
// Module   : tb_divider_arbiter
// Brief    : Directed self-checking bench for divider_arbiter with a divider model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_divider_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int TMO  = 255;

  logic                 clk = 1'b0;
  logic                 arst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0, req_ready, rsp_valid, rsp_ready = '1;
  logic [NREQ*DW-1:0]   req_dividend = '0, req_divisor = '0;
  logic [DW-1:0]        rsp_quotient, div_dividend, div_divisor, div_quotient;
  logic                 rsp_dbz, rsp_err, div_valid, div_vld, div_busy;

  int checks = 0, errors = 0, cyc = 0, dv_count = 0;
  int lat = 64, stale_hold = 0;
  bit hang = 1'b0;

  logic [DW-1:0] m_a, m_b, m_q;
  logic          m_vld, m_busy;
  int            m_cnt, m_hold;

  divider_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .arst         (arst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_dbz      (rsp_dbz),
    .rsp_err      (rsp_err),
    .div_valid    (div_valid),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_vld      (div_vld),
    .div_busy     (div_busy)
  );

  always #5 clk = ~clk;

  // Divider model: result after lat cycles; vld may linger stale_hold cycles after a start.
  always @(posedge clk or negedge arst) begin
    if (!arst) begin
      m_vld <= 1'b0; m_busy <= 1'b0; m_q <= '0; m_a <= '0; m_b <= '0;
      m_cnt <= 0; m_hold <= 0;
    end else if (div_valid) begin
      m_a    <= div_dividend;
      m_b    <= div_divisor;
      m_hold <= stale_hold;
      m_cnt  <= lat;
      m_busy <= !hang;
      if (stale_hold == 0 || hang) m_vld <= 1'b0;
    end else if (m_busy) begin
      if (m_hold > 1) m_hold <= m_hold - 1;
      else if (m_hold == 1) begin m_hold <= 0; m_vld <= 1'b0; end
      if (m_cnt > 1) m_cnt <= m_cnt - 1;
      else begin m_busy <= 1'b0; m_vld <= 1'b1; m_q <= m_a / m_b; end
    end
  end

  assign div_quotient = m_q;
  assign div_vld      = m_vld;
  assign div_busy     = m_busy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_valid) dv_count <= dv_count + 1;
  end

  task automatic do_reset();
    @(negedge clk); arst = 1'b0;
    @(negedge clk); arst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue_req(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           output int acc, output logic [NREQ-1:0] rdy, output bit ok);
    acc = 0; rdy = '0; ok = 1'b0;
    req_dividend[r*DW +: DW] = a;
    req_divisor[r*DW +: DW]  = b;
    req_valid[r] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready[r]) begin ok = 1'b1; acc = cyc; rdy = req_ready; break; end
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r, output int rc, output bit ok);
    rc = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp_valid[r]) begin ok = 1'b1; rc = cyc; break; end
    end
  endtask

  task automatic test_reset();
    arst = 1'b0; req_valid = '1; rsp_ready = '1;
    req_dividend = {NREQ{64'd9}}; req_divisor = {NREQ{64'd3}};
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_quotient !== '0) begin errors++; $display("FAIL reset_quotient: got %0h expected 0", rsp_quotient); end
    checks++; if ({rsp_dbz, rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {rsp_dbz, rsp_err}); end
    checks++; if (div_valid !== 1'b0) begin errors++; $display("FAIL reset_div_valid: got %b expected 0", div_valid); end
    checks++; if ({div_dividend, div_divisor} !== '0) begin errors++; $display("FAIL reset_div_ops: got %0h/%0h expected 0/0", div_dividend, div_divisor); end
    req_valid = '0; arst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int acc, rc, d0; logic [NREQ-1:0] rdy; bit ok;
    lat = 64; stale_hold = 0; hang = 1'b0; d0 = dv_count;
    issue_req(0, 64'd100, 64'd7, acc, rdy, ok);
    checks++; if (!ok || rdy !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", rdy); end
    wait_rsp(0, rc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_rsp_timeout: got no rsp_valid expected rsp_valid[0]"); end
    checks++; if (rc - acc !== 67) begin errors++; $display("FAIL single_latency: got %0d expected 67", rc - acc); end
    checks++; if (rsp_quotient !== 64'd14) begin errors++; $display("FAIL single_quotient: got %0d expected 14", rsp_quotient); end
    checks++; if ({rsp_dbz, rsp_err} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b expected 00", {rsp_dbz, rsp_err}); end
    checks++; if (dv_count - d0 !== 1) begin errors++; $display("FAIL single_div_pulses: got %0d expected 1", dv_count - d0); end
    checks++; if (m_a !== 64'd100 || m_b !== 64'd7) begin errors++; $display("FAIL single_div_ops: got %0d/%0d expected 100/7", m_a, m_b); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_idx [5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] exp_q [5] = '{64'd333, 64'd11, 64'd123456, 64'h0FFF_FFFF_FFFF_FFFF, 64'd9};
    int seen, rc; bit ok;
    do_reset();
    lat = 10;
    req_dividend[0*DW +: DW] = 64'd1000;      req_divisor[0*DW +: DW] = 64'd3;
    req_dividend[1*DW +: DW] = 64'd77;        req_divisor[1*DW +: DW] = 64'd7;
    req_dividend[2*DW +: DW] = 64'd123456789; req_divisor[2*DW +: DW] = 64'd1000;
    req_dividend[3*DW +: DW] = '1;            req_divisor[3*DW +: DW] = 64'd16;
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      seen = -1;
      for (int i = 0; i < 100 && seen < 0; i++) begin
        @(negedge clk);
        for (int j = 0; j < NREQ; j++) if (req_ready[j] && seen < 0) seen = j;
      end
      checks++;
      if (seen != exp_idx[k] || !$onehot(req_ready)) begin
        errors++; $display("FAIL rr_order_%0d: got grant %b expected index %0d", k, req_ready, exp_idx[k]);
        break;
      end
      @(posedge clk); #1;
      if (k == 0) begin req_dividend[0*DW +: DW] = 64'd81; req_divisor[0*DW +: DW] = 64'd9; end
      if (k == 4) req_valid = '0;
      wait_rsp(seen, rc, ok);
      checks++; if (!ok || rsp_quotient !== exp_q[k]) begin errors++; $display("FAIL rr_quotient_%0d: got %0h expected %0h", k, rsp_quotient, exp_q[k]); end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_dbz();
    int acc, rc, d0; logic [NREQ-1:0] rdy; bit ok;
    rsp_ready = 4'b1011; d0 = dv_count;
    issue_req(2, 64'd5, 64'd0, acc, rdy, ok);
    checks++; if (!ok || rdy !== 4'b0100) begin errors++; $display("FAIL dbz_grant: got %b expected 0100", rdy); end
    wait_rsp(2, rc, ok);
    checks++; if (!ok || rc - acc !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", rc - acc); end
    checks++; if (rsp_quotient !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL dbz_quotient: got %0h expected ffffffffffffffff", rsp_quotient); end
    checks++; if ({rsp_dbz, rsp_err} !== 2'b10) begin errors++; $display("FAIL dbz_flags: got %b expected 10", {rsp_dbz, rsp_err}); end
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_quotient !== 64'hFFFF_FFFF_FFFF_FFFF || rsp_dbz !== 1'b1) begin
      errors++; $display("FAIL dbz_hold: got valid %b q %0h dbz %b expected 0100 ffffffffffffffff 1", rsp_valid, rsp_quotient, rsp_dbz);
    end
    rsp_ready[2] = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== '0 || rsp_dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear: got valid %b dbz %b expected 0000 0", rsp_valid, rsp_dbz); end
    checks++; if (dv_count != d0) begin errors++; $display("FAIL dbz_no_div_valid: got %0d pulses expected 0", dv_count - d0); end
    rsp_ready = '1;
  endtask

  task automatic test_stale_vld();
    int acc, rc; logic [NREQ-1:0] rdy; bit ok;
    lat = 20; stale_hold = 5;
    issue_req(1, 64'd200, 64'd8, acc, rdy, ok);
    wait_rsp(1, rc, ok);
    checks++; if (!ok || rc - acc !== 23) begin errors++; $display("FAIL stale_latency: got %0d expected 23", rc - acc); end
    checks++; if (rsp_quotient !== 64'd25) begin errors++; $display("FAIL stale_quotient: got %0d expected 25", rsp_quotient); end
    @(posedge clk); #1;
    stale_hold = 0;
  endtask

  task automatic test_timeout();
    int acc, rc, d0; logic [NREQ-1:0] rdy; bit ok;
    hang = 1'b1; d0 = dv_count;
    issue_req(3, 64'd42, 64'd6, acc, rdy, ok);
    wait_rsp(3, rc, ok);
    checks++; if (!ok || rc - acc !== 2 + TMO) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", rc - acc, 2 + TMO); end
    checks++; if (rsp_quotient !== '0) begin errors++; $display("FAIL tmo_quotient: got %0h expected 0", rsp_quotient); end
    checks++; if ({rsp_dbz, rsp_err} !== 2'b01) begin errors++; $display("FAIL tmo_flags: got %b expected 01", {rsp_dbz, rsp_err}); end
    checks++; if (dv_count - d0 !== 1) begin errors++; $display("FAIL tmo_div_pulses: got %0d expected 1", dv_count - d0); end
    @(posedge clk); #1;
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL tmo_err_clear: got %b expected 0", rsp_err); end
    hang = 1'b0; lat = 20;
    issue_req(0, 64'd50, 64'd5, acc, rdy, ok);
    wait_rsp(0, rc, ok);
    checks++; if (!ok || rc - acc !== 23 || rsp_quotient !== 64'd10 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL tmo_recover: got lat %0d q %0d err %b expected 23 10 0", rc - acc, rsp_quotient, rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int acc, rc; logic [NREQ-1:0] rdy; bit ok;
    lat = 64;
    issue_req(2, 64'd300, 64'd3, acc, rdy, ok);
    repeat (10) @(negedge clk);
    req_dividend[1*DW +: DW] = 64'd77; req_divisor[1*DW +: DW] = 64'd11;
    req_valid[1] = 1'b1;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL busy_no_accept: got %b expected 0000", req_ready); end
    checks++; if (div_dividend !== 64'd300 || div_divisor !== 64'd3) begin errors++; $display("FAIL wait_ops_hold: got %0d/%0d expected 300/3", div_dividend, div_divisor); end
    arst = 1'b0;
    #1;
    checks++; if ({req_ready, rsp_valid} !== '0 || div_valid !== 1'b0) begin errors++; $display("FAIL arst_handshake_outs: got %b %b %b expected 0", req_ready, rsp_valid, div_valid); end
    checks++; if (rsp_quotient !== '0 || {rsp_dbz, rsp_err} !== 2'b00) begin errors++; $display("FAIL arst_rsp_outs: got %0h %b expected 0 00", rsp_quotient, {rsp_dbz, rsp_err}); end
    checks++; if (div_dividend !== '0 || div_divisor !== '0) begin errors++; $display("FAIL arst_div_ops: got %0h/%0h expected 0/0", div_dividend, div_divisor); end
    @(negedge clk);
    req_dividend[0*DW +: DW] = 64'd90; req_divisor[0*DW +: DW] = 64'd9;
    req_valid[0] = 1'b1;
    arst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_grant: got %b expected 0001", req_ready); end
    lat = 5;
    issue_req(0, 64'd90, 64'd9, acc, rdy, ok);
    wait_rsp(0, rc, ok);
    checks++; if (!ok || rsp_quotient !== 64'd10) begin errors++; $display("FAIL post_reset_q0: got %0d expected 10", rsp_quotient); end
    @(posedge clk); #1;
    issue_req(1, 64'd77, 64'd11, acc, rdy, ok);
    checks++; if (!ok || rdy !== 4'b0010) begin errors++; $display("FAIL post_reset_grant1: got %b expected 0010", rdy); end
    wait_rsp(1, rc, ok);
    checks++; if (!ok || rsp_quotient !== 64'd7) begin errors++; $display("FAIL post_reset_q1: got %0d expected 7", rsp_quotient); end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dbz();
    test_stale_vld();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
